// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared DMI definitions for the debug-module side of the DTM link: packed
// request/response layouts as they appear on the DMI FIFO pair, the operation
// and response encodings, and the raw widths of both FIFO words.
// No ports (package).
// -----------------------------------------------------------------------------
package dm_pkg;

  localparam int DmiReqWidth  = 41;
  localparam int DmiRespWidth = 34;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'd0,
    DTM_READ  = 2'd1,
    DTM_WRITE = 2'd2,
    DTM_RSVD  = 2'd3
  } dtm_op_e;

  // Encoding 1 is reserved on the wire and never produced here.
  typedef enum logic [1:0] {
    DMI_SUCCESS = 2'd0,
    DMI_FAILED  = 2'd2,
    DMI_BUSY    = 2'd3
  } dmi_resp_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    dtm_op_e     op;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    dmi_resp_e   resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_reg_bridge.sv
// -----------------------------------------------------------------------------
// dmi_reg_bridge
// Core-domain consumer of the DMI request/response FIFO pair. One DMI request
// is accepted at a time and turned into a single req/gnt/rvalid register-bus
// transaction; the completion (or a watchdog expiry) becomes one DMI response.
//
// Ports
//   clk_i, rst_i            core clock, synchronous active-high reset
//   dmi_req_i[40:0]         {addr[6:0], data[31:0], op[1:0]}
//   dmi_req_valid_i/ready_o request handshake (ready only in IDLE)
//   dmi_resp_o[33:0]        {data[31:0], resp[1:0]}
//   dmi_resp_valid_o/ready_i response handshake
//   reg_req_o, reg_we_o,    register-bus request, held stable until grant
//   reg_addr_o, reg_wdata_o
//   reg_gnt_i               grant of the current request
//   reg_rvalid_i, reg_rdata_i, reg_error_i   completion with read data/error
// -----------------------------------------------------------------------------
module dmi_reg_bridge
  import dm_pkg::*;
#(
  parameter int AddrWidth     = 7,
  parameter int TimeoutCycles = 255,
  parameter bit NopResponds   = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic [DmiReqWidth-1:0]  dmi_req_i,
  input  logic                    dmi_req_valid_i,
  output logic                    dmi_req_ready_o,

  output logic [DmiRespWidth-1:0] dmi_resp_o,
  output logic                    dmi_resp_valid_o,
  input  logic                    dmi_resp_ready_i,

  output logic                    reg_req_o,
  output logic                    reg_we_o,
  output logic [AddrWidth-1:0]    reg_addr_o,
  output logic [31:0]             reg_wdata_o,
  input  logic                    reg_gnt_i,
  input  logic                    reg_rvalid_i,
  input  logic [31:0]             reg_rdata_i,
  input  logic                    reg_error_i
);

  localparam int CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                state_q,      state_d;
  logic                  reg_req_q,    reg_req_d;
  logic                  reg_we_q,     reg_we_d;
  logic [AddrWidth-1:0]  reg_addr_q,   reg_addr_d;
  logic [31:0]           reg_wdata_q,  reg_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  dmi_resp_t             resp_q,       resp_d;
  logic [CntW-1:0]       cnt_q,        cnt_d;

  dmi_req_t              req;
  logic                  completion;
  logic                  expiring;

  assign req = dmi_req_t'(dmi_req_i);

  // A completion is either rvalid together with the grant while still
  // issuing, or rvalid while waiting. rvalid seen anywhere else is stale.
  assign completion = ((state_q == ST_ISSUE) && reg_gnt_i && reg_rvalid_i) ||
                      ((state_q == ST_WAIT)  && reg_rvalid_i);

  // cnt_q counts ISSUE/WAIT cycles already spent; this cycle is the last
  // one allowed when it equals TimeoutCycles-1.
  assign expiring = (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    state_d      = state_q;
    reg_req_d    = reg_req_q;
    reg_we_d     = reg_we_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (dmi_req_valid_i) begin
          unique case (req.op)
            DTM_READ, DTM_WRITE: begin
              state_d     = ST_ISSUE;
              reg_req_d   = 1'b1;
              reg_we_d    = (req.op == DTM_WRITE);
              reg_addr_d  = req.addr;
              reg_wdata_d = req.data;
              cnt_d       = '0;
            end
            DTM_RSVD: begin
              state_d      = ST_RESP;
              resp_valid_d = 1'b1;
              resp_d       = '{data: 32'h0, resp: DMI_FAILED};
            end
            default: begin
              // NOP: either acknowledged with an empty success or dropped.
              if (NopResponds) begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_d       = '{data: 32'h0, resp: DMI_SUCCESS};
              end
            end
          endcase
        end
      end

      ST_ISSUE, ST_WAIT: begin
        if (cnt_q != CntW'(TimeoutCycles)) begin
          cnt_d = cnt_q + 1'b1;
        end

        // Completion takes priority over a watchdog expiry in the same cycle.
        if (completion) begin
          state_d      = ST_RESP;
          reg_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          if (reg_error_i) begin
            resp_d = '{data: 32'h0, resp: DMI_FAILED};
          end else begin
            resp_d = '{data: (reg_we_q ? 32'h0 : reg_rdata_i), resp: DMI_SUCCESS};
          end
        end else if (expiring) begin
          state_d      = ST_RESP;
          reg_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_d       = '{data: 32'h0, resp: DMI_FAILED};
        end else if ((state_q == ST_ISSUE) && reg_gnt_i) begin
          state_d   = ST_WAIT;
          reg_req_d = 1'b0;
        end
      end

      default: begin
        if (dmi_resp_ready_i) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      reg_req_q    <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '{data: 32'h0, resp: DMI_SUCCESS};
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      reg_req_q    <= reg_req_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      cnt_q        <= cnt_d;
    end
  end

  // Ready is a pure function of state, forced low while reset is held.
  assign dmi_req_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign dmi_resp_o       = resp_q;
  assign dmi_resp_valid_o = resp_valid_q;
  assign reg_req_o        = reg_req_q;
  assign reg_we_o         = reg_we_q;
  assign reg_addr_o       = reg_addr_q;
  assign reg_wdata_o      = reg_wdata_q;

endmodule
